// File: rtl/scpad_pkg.sv
// Shared widths, the scratchpad data beat type and the request-generator state encoding.
package scpad_pkg;

    localparam int DRAM_ADDR_WIDTH  = 32;
    localparam int DRAM_ID_WIDTH    = 4;
    localparam int COL_IDX_WIDTH    = 10;
    localparam int ROW_IDX_WIDTH    = 5;
    localparam int SCPAD_DATA_WIDTH = 512;

    typedef logic [SCPAD_DATA_WIDTH-1:0] scpad_data_t;

    typedef enum logic [2:0] {
        GEN_IDLE      = 3'd0,
        GEN_ISSUE     = 3'd1,
        GEN_SRAM_WAIT = 3'd2,
        GEN_PUSH      = 3'd3,
        GEN_DRAIN     = 3'd4
    } gen_state_t;

endpackage

// File: rtl/scpad_burst_splitter.sv
// Splits a tile row into bursts: request count, size of the selected burst and its byte offset.
module scpad_burst_splitter
    import scpad_pkg::*;
#(
    parameter int BURST_BYTES = 64
) (
    input  logic [COL_IDX_WIDTH-1:0] row_bytes,
    input  logic [2:0]               sub_id,
    output logic [2:0]               num_request,
    output logic [COL_IDX_WIDTH-1:0] num_bytes,
    output logic [COL_IDX_WIDTH-1:0] offset
);

    localparam int SHIFT = $clog2(BURST_BYTES);

    logic [COL_IDX_WIDTH:0]   padded;
    logic [COL_IDX_WIDTH-1:0] remainder;

    // ceil-divide the row into bursts; only the last burst may be short
    always_comb begin
        padded      = {1'b0, row_bytes} + (COL_IDX_WIDTH+1)'(BURST_BYTES - 1);
        num_request = 3'(padded >> SHIFT);
        remainder   = row_bytes & COL_IDX_WIDTH'(BURST_BYTES - 1);
        offset      = COL_IDX_WIDTH'(sub_id) << SHIFT;
        if ((sub_id == (num_request - 3'd1)) && (remainder != '0)) begin
            num_bytes = remainder;
        end else begin
            num_bytes = COL_IDX_WIDTH'(BURST_BYTES);
        end
    end

endmodule

// File: rtl/scpad_dram_req_gen.sv
// Turns one tile load/store command into DRAM bursts, fetching store data from SRAM,
// and reports tile completion once every row has been acknowledged.
//
// state     | meaning
// IDLE      | ready for a command
// ISSUE     | load: push current burst; store: launch SRAM read
// SRAM_WAIT | store: waiting for the SRAM beat
// PUSH      | store: push the captured beat with its burst fields
// DRAIN     | all bursts pushed, waiting for row completions / done pulse
module scpad_dram_req_gen
    import scpad_pkg::*;
#(
    parameter int BURST_BYTES = 64,
    parameter int MAX_ROWS    = 32,
    parameter int ROW_CNT_W   = $clog2(MAX_ROWS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_req_valid,
    output logic                       sched_req_ready,
    input  logic                       sched_write,
    input  logic [DRAM_ADDR_WIDTH-1:0] sched_dram_addr,
    input  logic [DRAM_ADDR_WIDTH-1:0] sched_row_stride,
    input  logic [DRAM_ID_WIDTH-1:0]   sched_id,
    input  logic [ROW_CNT_W-1:0]       sched_num_rows,
    input  logic [COL_IDX_WIDTH-1:0]   sched_row_bytes,
    output logic                       sched_done,
    output logic                       sram_rd_en,
    output logic [ROW_IDX_WIDTH-1:0]   sram_rd_row,
    output logic [COL_IDX_WIDTH-1:0]   sram_rd_col,
    input  logic                       sram_res_valid,
    input  scpad_data_t                sram_rdata,
    output logic                       q_valid,
    output logic                       q_write,
    output logic [DRAM_ADDR_WIDTH-1:0] q_dram_addr,
    output logic [DRAM_ID_WIDTH-1:0]   q_id,
    output logic [2:0]                 q_sub_id,
    output logic [2:0]                 q_num_request,
    output logic [COL_IDX_WIDTH-1:0]   q_num_bytes,
    output scpad_data_t                q_sram_rdata,
    input  logic                       dram_queue_full,
    input  logic                       be_stall,
    input  logic                       transaction_complete
);

    gen_state_t                 state_q, state_d;
    logic                       write_q, write_d;
    logic [DRAM_ID_WIDTH-1:0]   id_q, id_d;
    logic [DRAM_ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [DRAM_ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ROW_CNT_W-1:0]       num_rows_q, num_rows_d;
    logic [COL_IDX_WIDTH-1:0]   row_bytes_q, row_bytes_d;
    logic [ROW_CNT_W-1:0]       row_idx_q, row_idx_d;
    logic [ROW_CNT_W-1:0]       rows_done_q, rows_done_d;
    logic                       all_pushed_q, all_pushed_d;
    logic                       done_q, done_d;
    logic [DRAM_ADDR_WIDTH-1:0] q_dram_addr_q, q_dram_addr_d;
    logic [2:0]                 q_sub_id_q, q_sub_id_d;
    logic [2:0]                 q_num_request_q, q_num_request_d;
    logic [COL_IDX_WIDTH-1:0]   q_num_bytes_q, q_num_bytes_d;
    scpad_data_t                q_sram_rdata_q, q_sram_rdata_d;

    logic                       push, fields_ld, last_sub, last_row;
    logic [2:0]                 sp_num_request;
    logic [COL_IDX_WIDTH-1:0]   sp_num_bytes, sp_offset;

    // burst fields are computed for the next burst so they can be registered ahead of the push
    scpad_burst_splitter #(.BURST_BYTES(BURST_BYTES)) u_splitter (
        .row_bytes   (row_bytes_d),
        .sub_id      (q_sub_id_d),
        .num_request (sp_num_request),
        .num_bytes   (sp_num_bytes),
        .offset      (sp_offset)
    );

    // next-state, burst sequencing and completion tracking
    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        id_d            = id_q;
        stride_d        = stride_q;
        row_base_d      = row_base_q;
        num_rows_d      = num_rows_q;
        row_bytes_d     = row_bytes_q;
        row_idx_d       = row_idx_q;
        rows_done_d     = rows_done_q;
        all_pushed_d    = all_pushed_q;
        done_d          = 1'b0;
        q_dram_addr_d   = q_dram_addr_q;
        q_sub_id_d      = q_sub_id_q;
        q_num_request_d = q_num_request_q;
        q_num_bytes_d   = q_num_bytes_q;
        q_sram_rdata_d  = q_sram_rdata_q;
        push            = 1'b0;
        fields_ld       = 1'b0;
        sram_rd_en      = 1'b0;
        q_valid         = 1'b0;
        last_sub        = (q_sub_id_q == (q_num_request_q - 3'd1));
        last_row        = (row_idx_q == (num_rows_q - ROW_CNT_W'(1)));

        case (state_q)
            GEN_IDLE: begin
                if (sched_req_valid) begin
                    write_d      = sched_write;
                    id_d         = sched_id;
                    stride_d     = sched_row_stride;
                    row_base_d   = sched_dram_addr;
                    num_rows_d   = sched_num_rows;
                    row_bytes_d  = sched_row_bytes;
                    row_idx_d    = '0;
                    rows_done_d  = '0;
                    all_pushed_d = 1'b0;
                    q_sub_id_d   = '0;
                    fields_ld    = 1'b1;
                    state_d      = GEN_ISSUE;
                end
            end
            GEN_ISSUE: begin
                if (write_q) begin
                    if (!be_stall) begin
                        sram_rd_en = 1'b1;
                        state_d    = GEN_SRAM_WAIT;
                    end
                end else begin
                    q_valid = !dram_queue_full && !be_stall;
                    push    = q_valid;
                end
            end
            GEN_SRAM_WAIT: begin
                if (sram_res_valid) begin
                    q_sram_rdata_d = sram_rdata;
                    state_d        = GEN_PUSH;
                end
            end
            GEN_PUSH: begin
                q_valid = !dram_queue_full && !be_stall;
                push    = q_valid;
                if (push) begin
                    state_d = GEN_ISSUE;
                end
            end
            default: ;
        endcase

        if (push) begin
            if (last_sub && last_row) begin
                all_pushed_d = 1'b1;
                state_d      = GEN_DRAIN;
            end else begin
                fields_ld = 1'b1;
                if (last_sub) begin
                    q_sub_id_d = '0;
                    row_idx_d  = row_idx_q + ROW_CNT_W'(1);
                    row_base_d = row_base_q + stride_q;
                end else begin
                    q_sub_id_d = q_sub_id_q + 3'd1;
                end
            end
        end

        if ((state_q != GEN_IDLE) && transaction_complete) begin
            rows_done_d = rows_done_q + ROW_CNT_W'(1);
        end

        // done fires once, the cycle after both the last push and last completion are in
        if ((state_q != GEN_IDLE) && !done_q && all_pushed_d && (rows_done_d >= num_rows_q)) begin
            done_d = 1'b1;
        end
        if (done_q) begin
            state_d = GEN_IDLE;
        end

        if (fields_ld) begin
            q_dram_addr_d   = row_base_d + DRAM_ADDR_WIDTH'(sp_offset);
            q_num_request_d = sp_num_request;
            q_num_bytes_d   = sp_num_bytes;
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= GEN_IDLE;
            write_q         <= 1'b0;
            id_q            <= '0;
            stride_q        <= '0;
            row_base_q      <= '0;
            num_rows_q      <= '0;
            row_bytes_q     <= '0;
            row_idx_q       <= '0;
            rows_done_q     <= '0;
            all_pushed_q    <= 1'b0;
            done_q          <= 1'b0;
            q_dram_addr_q   <= '0;
            q_sub_id_q      <= '0;
            q_num_request_q <= '0;
            q_num_bytes_q   <= '0;
            q_sram_rdata_q  <= '0;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            id_q            <= id_d;
            stride_q        <= stride_d;
            row_base_q      <= row_base_d;
            num_rows_q      <= num_rows_d;
            row_bytes_q     <= row_bytes_d;
            row_idx_q       <= row_idx_d;
            rows_done_q     <= rows_done_d;
            all_pushed_q    <= all_pushed_d;
            done_q          <= done_d;
            q_dram_addr_q   <= q_dram_addr_d;
            q_sub_id_q      <= q_sub_id_d;
            q_num_request_q <= q_num_request_d;
            q_num_bytes_q   <= q_num_bytes_d;
            q_sram_rdata_q  <= q_sram_rdata_d;
        end
    end

    assign sched_req_ready = (state_q == GEN_IDLE);
    assign sched_done      = done_q;
    assign sram_rd_row     = row_idx_q[ROW_IDX_WIDTH-1:0];
    assign sram_rd_col     = COL_IDX_WIDTH'(q_sub_id_q) << $clog2(BURST_BYTES);
    assign q_write         = write_q;
    assign q_id            = id_q;
    assign q_dram_addr     = q_dram_addr_q;
    assign q_sub_id        = q_sub_id_q;
    assign q_num_request   = q_num_request_q;
    assign q_num_bytes     = q_num_bytes_q;
    assign q_sram_rdata    = q_sram_rdata_q;

endmodule

// File: tb/tb_scpad_dram_req_gen.sv
// Bench for scpad_dram_req_gen: directed scenarios plus randomized commands, each checked
// against an expected burst list built directly from the command fields.
module tb_scpad_dram_req_gen;
    import scpad_pkg::*;

    localparam int BB  = 64;
    localparam int RCW = 6;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       sched_req_valid, sched_req_ready, sched_write;
    logic [DRAM_ADDR_WIDTH-1:0] sched_dram_addr, sched_row_stride;
    logic [DRAM_ID_WIDTH-1:0]   sched_id;
    logic [RCW-1:0]             sched_num_rows;
    logic [COL_IDX_WIDTH-1:0]   sched_row_bytes;
    logic                       sched_done, sram_rd_en;
    logic [ROW_IDX_WIDTH-1:0]   sram_rd_row;
    logic [COL_IDX_WIDTH-1:0]   sram_rd_col;
    logic                       sram_res_valid;
    scpad_data_t                sram_rdata;
    logic                       q_valid, q_write;
    logic [DRAM_ADDR_WIDTH-1:0] q_dram_addr;
    logic [DRAM_ID_WIDTH-1:0]   q_id;
    logic [2:0]                 q_sub_id, q_num_request;
    logic [COL_IDX_WIDTH-1:0]   q_num_bytes;
    scpad_data_t                q_sram_rdata;
    logic                       dram_queue_full, be_stall, transaction_complete;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        int          row;
        int          sub;
        int          nreq;
        int          nbytes;
    } burst_t;

    always #5 clk = ~clk;

    scpad_dram_req_gen #(.BURST_BYTES(64), .MAX_ROWS(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sched_req_valid      (sched_req_valid),
        .sched_req_ready      (sched_req_ready),
        .sched_write          (sched_write),
        .sched_dram_addr      (sched_dram_addr),
        .sched_row_stride     (sched_row_stride),
        .sched_id             (sched_id),
        .sched_num_rows       (sched_num_rows),
        .sched_row_bytes      (sched_row_bytes),
        .sched_done           (sched_done),
        .sram_rd_en           (sram_rd_en),
        .sram_rd_row          (sram_rd_row),
        .sram_rd_col          (sram_rd_col),
        .sram_res_valid       (sram_res_valid),
        .sram_rdata           (sram_rdata),
        .q_valid              (q_valid),
        .q_write              (q_write),
        .q_dram_addr          (q_dram_addr),
        .q_id                 (q_id),
        .q_sub_id             (q_sub_id),
        .q_num_request        (q_num_request),
        .q_num_bytes          (q_num_bytes),
        .q_sram_rdata         (q_sram_rdata),
        .dram_queue_full      (dram_queue_full),
        .be_stall             (be_stall),
        .transaction_complete (transaction_complete)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_cmd(input bit wr, input logic [31:0] base, input logic [31:0] stride,
                           input logic [3:0] id, input int rows, input int bytes, input int lat,
                           input int stall_pct, input int full_from, input int full_len,
                           input int tc_final_at, input bit hold_valid);
        burst_t       exp_q[$];
        logic [511:0] dat_q[$];
        int           tc_due[$];
        burst_t       b;
        int nreq, total, n, cyc, pushes, tcs, resp_at, exp_done;
        bit rd_out, prev_push, tc_now, strict;
        logic [52:0]  prev_fields, cur_fields;

        nreq   = (bytes + BB - 1) / BB;
        total  = rows * nreq;
        strict = (stall_pct == 0) && (full_len == 0);
        for (int r = 0; r < rows; r++) begin
            for (int s = 0; s < nreq; s++) begin
                b.addr   = base + 32'(r) * stride + 32'(s * BB);
                b.row    = r;
                b.sub    = s;
                b.nreq   = nreq;
                b.nbytes = (s == nreq - 1) ? bytes - (nreq - 1) * BB : BB;
                exp_q.push_back(b);
            end
        end

        @(posedge clk); #1;
        sched_req_valid  = 1'b1;
        sched_write      = wr;
        sched_dram_addr  = base;
        sched_row_stride = stride;
        sched_id         = id;
        sched_num_rows   = RCW'(rows);
        sched_row_bytes  = COL_IDX_WIDTH'(bytes);
        n = 0;
        @(negedge clk);
        while (!sched_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", sched_req_ready, 1);
        @(posedge clk); #1;
        if (!hold_valid) sched_req_valid = 1'b0;

        cyc = 1; pushes = 0; tcs = 0; resp_at = -1; exp_done = 0;
        rd_out = 0; prev_push = 1; prev_fields = '0;
        while (1) begin
            be_stall        = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            dram_queue_full = (cyc >= full_from && cyc < full_from + full_len) ||
                              ((stall_pct > 0) && ($urandom_range(99) < stall_pct));
            sram_res_valid  = (resp_at == cyc);
            sram_rdata      = rnd512();
            if (sram_res_valid) dat_q.push_back(sram_rdata);
            tc_now = 0;
            if (cyc == tc_final_at) tc_now = 1;
            else if (tc_due.size() > 0 && tc_due[0] <= cyc) begin
                tc_now = 1;
                void'(tc_due.pop_front());
            end
            transaction_complete = tc_now;

            @(negedge clk);
            chk("sched_done", sched_done, (exp_done != 0 && cyc == exp_done));
            chk("ready_busy", sched_req_ready, 0);
            if (tc_now) tcs++;
            if (q_valid) chk("q_valid_blocked", be_stall | dram_queue_full, 0);
            if (sram_rd_en) chk("rd_en_stall", be_stall, 0);
            cur_fields = {q_dram_addr, q_sub_id, q_num_request, q_num_bytes, q_write, q_id};
            if (!prev_push && cyc > 1) chk("hold_fields", cur_fields, prev_fields);

            if (sram_rd_en) begin
                chk("rd_en_is_store", wr, 1);
                chk("rd_dup", rd_out, 0);
                if (exp_q.size() == 0) chk("rd_extra", sram_rd_en, 0);
                else begin
                    chk("rd_row", sram_rd_row, exp_q[0].row);
                    chk("rd_col", sram_rd_col, exp_q[0].sub * BB);
                end
                if (strict) chk("rd_cycle", cyc, pushes * (lat + 2) + 1);
                rd_out  = 1;
                resp_at = cyc + lat;
            end

            if (q_valid) begin
                if (exp_q.size() == 0) chk("extra_push", q_valid, 0);
                else begin
                    b = exp_q.pop_front();
                    chk("q_dram_addr", q_dram_addr, b.addr);
                    chk("q_sub_id", q_sub_id, b.sub);
                    chk("q_num_request", q_num_request, b.nreq);
                    chk("q_num_bytes", q_num_bytes, b.nbytes);
                    chk("q_write", q_write, wr);
                    chk("q_id", q_id, id);
                    if (wr) begin
                        if (dat_q.size() == 0) chk("push_without_data", q_valid, 0);
                        else chk("q_sram_rdata", q_sram_rdata, dat_q.pop_front());
                        rd_out = 0;
                    end
                    pushes++;
                    if (strict) chk("push_cycle", cyc, pushes * (wr ? lat + 2 : 1));
                    if (b.sub == nreq - 1 && !(tc_final_at != 0 && b.row == rows - 1))
                        tc_due.push_back(cyc + $urandom_range(1, 3));
                end
            end
            prev_push   = q_valid;
            prev_fields = cur_fields;

            if (exp_done == 0 && pushes == total && tcs == rows) exp_done = cyc + 1;
            if (exp_done != 0 && cyc == exp_done) break;
            if (cyc > 3000) begin
                chk("cmd_timeout", cyc, exp_done);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end

        @(posedge clk); #1;
        sched_req_valid      = 1'b0;
        transaction_complete = 1'b0;
        sram_res_valid       = 1'b0;
        be_stall             = 1'b0;
        dram_queue_full      = 1'b0;
        @(negedge clk);
        chk("idle_ready", sched_req_ready, 1);
        chk("idle_no_done", sched_done, 0);
        chk("idle_no_push", q_valid, 0);
        chk("all_pushed", pushes, total);
    endtask

    initial begin
        rst = 1'b1;
        sched_req_valid = 0; sched_write = 0; sched_dram_addr = '0; sched_row_stride = '0;
        sched_id = '0; sched_num_rows = '0; sched_row_bytes = '0; sram_res_valid = 0;
        sram_rdata = '0; dram_queue_full = 0; be_stall = 0; transaction_complete = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", sched_req_ready, 1);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_rd_en", sram_rd_en, 0);
        chk("rst_done", sched_done, 0);
        chk("rst_q_addr", q_dram_addr, 0);
        chk("rst_q_num_bytes", q_num_bytes, 0);
        chk("rst_q_rdata", q_sram_rdata, 0);
        chk("rst_rd_col", sram_rd_col, 0);

        // two-row load from the worked example
        run_cmd(0, 32'h1000, 32'h200, 4'd5, 2, 160, 1, 0, 0, 0, 0, 0);
        // single-burst store with SRAM latency 2
        run_cmd(1, 32'h2000, 32'h40, 4'd3, 1, 64, 2, 0, 0, 0, 0, 0);
        // queue full for five cycles mid-load
        run_cmd(0, 32'h8000, 32'h400, 4'd7, 3, 200, 1, 0, 2, 5, 0, 0);
        // last completion in the same cycle as the final push
        run_cmd(0, 32'h3000, 32'h100, 4'd9, 1, 192, 1, 0, 0, 0, 3, 0);
        // request held valid while busy
        run_cmd(0, 32'h4000, 32'h80, 4'd2, 2, 128, 1, 0, 0, 0, 0, 1);
        // boundaries: seven exact bursts, one-byte row, 32 rows with address wrap
        run_cmd(1, 32'h5000, 32'h1000, 4'd1, 2, 448, 1, 0, 0, 0, 0, 0);
        run_cmd(0, 32'h6000, 32'h10, 4'd4, 1, 1, 1, 0, 0, 0, 0, 0);
        run_cmd(0, 32'hFFFF_FFC0, 32'hFFFF_FF00, 4'd15, 32, 65, 1, 0, 0, 0, 0, 0);

        // reset while the store waits on SRAM, then a late response
        @(posedge clk); #1;
        sched_req_valid = 1; sched_write = 1; sched_dram_addr = 32'h7000;
        sched_row_stride = 32'h40; sched_id = 4'd6; sched_num_rows = RCW'(1);
        sched_row_bytes = COL_IDX_WIDTH'(64);
        @(posedge clk); #1;
        sched_req_valid = 0;
        @(negedge clk);
        chk("abort_rd_en", sram_rd_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sram_res_valid = 1'b1;
        sram_rdata = rnd512();
        @(negedge clk);
        chk("abort_ready", sched_req_ready, 1);
        chk("abort_q_valid", q_valid, 0);
        chk("abort_done", sched_done, 0);
        chk("abort_q_addr", q_dram_addr, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            sram_res_valid = 1'b0;
            @(negedge clk);
            chk("abort_late_q_valid", q_valid, 0);
            chk("abort_late_done", sched_done, 0);
            chk("abort_late_rd_en", sram_rd_en, 0);
        end

        // randomized commands under random stalls and queue-full
        for (int t = 0; t < 14; t++) begin
            run_cmd(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)),
                    $urandom_range(1, 6), $urandom_range(1, 448), $urandom_range(1, 4),
                    25, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
